// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared types and constants for the instruction fetch path
package mips_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    VALID = 2'd2,
    DROP  = 2'd3
  } fetch_state_t;

  localparam int OPCODE_MSB = 31;
  localparam int OPCODE_LSB = 26;
  localparam int FUNCT_MSB  = 5;
  localparam int FUNCT_LSB  = 0;

  localparam int unsigned INSTR_BYTES = 4;

  // Clear the byte-offset bits so every fetch address is word aligned
  function automatic logic [31:0] align_pc(input logic [31:0] pc);
    return {pc[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - single-outstanding-request instruction fetch unit
module fetch_unit
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [5:0]  opcode,
  output logic [5:0]  funct,
  output logic [31:0] instr_pc,
  output logic [31:0] pc_plus4,
  output logic [31:0] fetch_count,
  output logic        misalign_err
);

  fetch_state_t state;
  logic [31:0]  fetch_pc;
  logic [31:0]  redirect_target;
  logic [31:0]  next_target;
  logic [31:0]  seq_pc;

  // A redirect always wins over the sequential fetch address
  assign redirect_target = align_pc(redirect_pc);
  assign next_target     = redirect_valid ? redirect_target : fetch_pc;
  assign seq_pc          = fetch_pc + 32'(INSTR_BYTES);

  // Decode fields and branch base are pure views of the held registers
  assign opcode   = instr[OPCODE_MSB:OPCODE_LSB];
  assign funct    = instr[FUNCT_MSB:FUNCT_LSB];
  assign pc_plus4 = instr_pc + 32'(INSTR_BYTES);

  // Fetch FSM; imem_addr only moves when no request is outstanding, so in
  // DROP it keeps the original address while fetch_pc tracks the new target
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state        <= IDLE;
      fetch_pc     <= RESET_PC;
      imem_req     <= 1'b0;
      imem_addr    <= RESET_PC;
      instr_valid  <= 1'b0;
      instr        <= 32'h0;
      instr_pc     <= 32'h0;
      fetch_count  <= 32'h0;
      misalign_err <= 1'b0;
    end else begin
      if (redirect_valid && (redirect_pc[1:0] != 2'b00)) begin
        misalign_err <= 1'b1;
      end

      case (state)
        IDLE: begin
          fetch_pc  <= next_target;
          imem_addr <= next_target;
          imem_req  <= 1'b1;
          state     <= FETCH;
        end

        FETCH: begin
          if (redirect_valid) begin
            fetch_pc <= redirect_target;
            if (imem_ack) begin
              imem_addr <= redirect_target;
            end else begin
              state <= DROP;
            end
          end else if (imem_ack) begin
            instr       <= imem_rdata;
            instr_pc    <= fetch_pc;
            fetch_pc    <= seq_pc;
            instr_valid <= 1'b1;
            imem_req    <= 1'b0;
            state       <= VALID;
          end
        end

        DROP: begin
          fetch_pc <= next_target;
          if (imem_ack) begin
            imem_addr <= next_target;
            state     <= FETCH;
          end
        end

        VALID: begin
          if (redirect_valid || !stall) begin
            fetch_count <= fetch_count + 32'd1;
            fetch_pc    <= next_target;
            imem_addr   <= next_target;
            instr_valid <= 1'b0;
            imem_req    <= 1'b1;
            state       <= FETCH;
          end
        end

        default: begin
          state    <= IDLE;
          imem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed self-checking bench for fetch_unit
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic [31:0] instr;
  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic [31:0] instr_pc;
  logic [31:0] pc_plus4;
  logic [31:0] fetch_count;
  logic        misalign_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Memory returns a word derived from the address it is asked for
  assign imem_rdata = imem_addr ^ 32'hDEAD_BEEF;

  fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .reset_n(reset_n),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .stall(stall), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .instr_valid(instr_valid), .instr(instr), .opcode(opcode), .funct(funct),
    .instr_pc(instr_pc), .pc_plus4(pc_plus4),
    .fetch_count(fetch_count), .misalign_err(misalign_err)
  );

  function automatic logic [31:0] exp_word(input logic [31:0] a);
    return a ^ 32'hDEAD_BEEF;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; imem_ack = 1'b0; stall = 1'b0;
    redirect_valid = 1'b0; redirect_pc = 32'h0;
    step();
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b expected 0", imem_req); end
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", instr_valid); end
    checks++; if (fetch_count !== 32'h0) begin errors++; $display("FAIL reset_count: got %h expected 0", fetch_count); end
    checks++; if (misalign_err !== 1'b0) begin errors++; $display("FAIL reset_misalign: got %b expected 0", misalign_err); end
    checks++; if (instr !== 32'h0 || instr_pc !== 32'h0) begin errors++; $display("FAIL reset_instr: got %h/%h expected 0/0", instr, instr_pc); end
  endtask

  task automatic test_stream();
    logic [31:0] w;
    imem_ack = 1'b1;
    reset_n  = 1'b1;
    step();
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin errors++; $display("FAIL stream_first_req: got %b/%h expected 1/00000000", imem_req, imem_addr); end
    for (int i = 0; i < 3; i++) begin
      step();
      w = exp_word(32'(4 * i));
      checks++; if (instr_valid !== 1'b1 || instr !== w) begin errors++; $display("FAIL stream_instr%0d: got %b/%h expected 1/%h", i, instr_valid, instr, w); end
      checks++; if (instr_pc !== 32'(4 * i) || pc_plus4 !== 32'(4 * i + 4)) begin errors++; $display("FAIL stream_pc%0d: got %h/%h expected %h/%h", i, instr_pc, pc_plus4, 4 * i, 4 * i + 4); end
      checks++; if (opcode !== w[31:26] || funct !== w[5:0]) begin errors++; $display("FAIL stream_fields%0d: got %h/%h expected %h/%h", i, opcode, funct, w[31:26], w[5:0]); end
      step();
      checks++; if (imem_req !== 1'b1 || imem_addr !== 32'(4 * i + 4)) begin errors++; $display("FAIL stream_addr%0d: got %b/%h expected 1/%h", i, imem_req, imem_addr, 4 * i + 4); end
      checks++; if (fetch_count !== 32'(i + 1)) begin errors++; $display("FAIL stream_count%0d: got %0d expected %0d", i, fetch_count, i + 1); end
    end
    step();
    checks++; if (instr_valid !== 1'b1 || instr_pc !== 32'hC) begin errors++; $display("FAIL stream_last: got %b/%h expected 1/0000000c", instr_valid, instr_pc); end
  endtask

  task automatic test_stall();
    stall = 1'b1; imem_ack = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      checks++; if (instr_valid !== 1'b1 || instr !== exp_word(32'hC) || instr_pc !== 32'hC) begin errors++; $display("FAIL stall_hold%0d: got %b/%h/%h expected 1/%h/0000000c", i, instr_valid, instr, instr_pc, exp_word(32'hC)); end
      checks++; if (imem_req !== 1'b0 || fetch_count !== 32'd3) begin errors++; $display("FAIL stall_req%0d: got %b/%0d expected 0/3", i, imem_req, fetch_count); end
    end
    stall = 1'b0;
    step();
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h10 || fetch_count !== 32'd4 || instr_valid !== 1'b0) begin errors++; $display("FAIL stall_release: got %b/%h/%0d/%b expected 1/00000010/4/0", imem_req, imem_addr, fetch_count, instr_valid); end
  endtask

  task automatic test_drop();
    redirect_valid = 1'b1; redirect_pc = 32'h100;
    step();
    redirect_valid = 1'b0;
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h10) begin errors++; $display("FAIL drop_enter: got %b/%h expected 1/00000010", imem_req, imem_addr); end
    for (int i = 0; i < 2; i++) begin
      step();
      checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h10) begin errors++; $display("FAIL drop_hold%0d: got %b/%h expected 1/00000010", i, imem_req, imem_addr); end
    end
    imem_ack = 1'b1;
    step();
    checks++; if (imem_addr !== 32'h100 || instr_valid !== 1'b0 || instr !== exp_word(32'hC)) begin errors++; $display("FAIL drop_discard: got %h/%b/%h expected 00000100/0/%h", imem_addr, instr_valid, instr, exp_word(32'hC)); end
    step();
    checks++; if (instr_valid !== 1'b1 || instr_pc !== 32'h100 || instr !== exp_word(32'h100)) begin errors++; $display("FAIL drop_target: got %b/%h/%h expected 1/00000100/%h", instr_valid, instr_pc, instr, exp_word(32'h100)); end
  endtask

  task automatic test_redirect_ack();
    imem_ack = 1'b0;
    step();
    checks++; if (imem_addr !== 32'h104 || fetch_count !== 32'd5) begin errors++; $display("FAIL rack_seq: got %h/%0d expected 00000104/5", imem_addr, fetch_count); end
    imem_ack = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h40;
    step();
    redirect_valid = 1'b0;
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h40 || instr_valid !== 1'b0) begin errors++; $display("FAIL rack_redirect: got %b/%h/%b expected 1/00000040/0", imem_req, imem_addr, instr_valid); end
    step();
    checks++; if (instr_valid !== 1'b1 || instr_pc !== 32'h40 || instr !== exp_word(32'h40)) begin errors++; $display("FAIL rack_target: got %b/%h/%h expected 1/00000040/%h", instr_valid, instr_pc, instr, exp_word(32'h40)); end
  endtask

  task automatic test_misalign();
    imem_ack = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h202;
    step();
    redirect_valid = 1'b0;
    checks++; if (imem_addr !== 32'h200 || misalign_err !== 1'b1 || fetch_count !== 32'd6) begin errors++; $display("FAIL misalign_redirect: got %h/%b/%0d expected 00000200/1/6", imem_addr, misalign_err, fetch_count); end
    imem_ack = 1'b1;
    step();
    checks++; if (instr_pc !== 32'h200 || misalign_err !== 1'b1) begin errors++; $display("FAIL misalign_sticky: got %h/%b expected 00000200/1", instr_pc, misalign_err); end
  endtask

  task automatic test_wrap();
    imem_ack = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    step();
    redirect_valid = 1'b0;
    checks++; if (imem_addr !== 32'hFFFF_FFFC || fetch_count !== 32'd7) begin errors++; $display("FAIL wrap_redirect: got %h/%0d expected fffffffc/7", imem_addr, fetch_count); end
    imem_ack = 1'b1;
    step();
    checks++; if (instr_pc !== 32'hFFFF_FFFC || pc_plus4 !== 32'h0) begin errors++; $display("FAIL wrap_pc: got %h/%h expected fffffffc/00000000", instr_pc, pc_plus4); end
    imem_ack = 1'b0;
    step();
    checks++; if (imem_addr !== 32'h0 || fetch_count !== 32'd8 || misalign_err !== 1'b1) begin errors++; $display("FAIL wrap_next: got %h/%0d/%b expected 00000000/8/1", imem_addr, fetch_count, misalign_err); end
  endtask

  task automatic test_reset_in_drop();
    redirect_valid = 1'b1; redirect_pc = 32'h80;
    step();
    redirect_valid = 1'b0;
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin errors++; $display("FAIL rdrop_enter: got %b/%h expected 1/00000000", imem_req, imem_addr); end
    reset_n = 1'b0; imem_ack = 1'b1;
    step();
    checks++; if (imem_req !== 1'b0 || instr_valid !== 1'b0 || fetch_count !== 32'h0 || misalign_err !== 1'b0) begin errors++; $display("FAIL rdrop_reset: got %b/%b/%0d/%b expected 0/0/0/0", imem_req, instr_valid, fetch_count, misalign_err); end
    checks++; if (instr !== 32'h0 || instr_pc !== 32'h0) begin errors++; $display("FAIL rdrop_instr: got %h/%h expected 0/0", instr, instr_pc); end
    reset_n = 1'b1;
    step();
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0 || instr_valid !== 1'b0) begin errors++; $display("FAIL rdrop_late_ack: got %b/%h/%b expected 1/00000000/0", imem_req, imem_addr, instr_valid); end
    step();
    checks++; if (instr_valid !== 1'b1 || instr_pc !== 32'h0 || fetch_count !== 32'h0) begin errors++; $display("FAIL rdrop_restart: got %b/%h/%0d expected 1/00000000/0", instr_valid, instr_pc, fetch_count); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_drop();
    test_redirect_ack();
    test_misalign();
    test_wrap();
    test_reset_in_drop();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
